// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax controller.
// Build option: define SOFTMAX_ARGMAX_EN to enable the argmax index output.
package softmax_pkg;

  localparam int NUM_CLASS_DEF = 7;
  localparam int FP_W          = 32;
  localparam int IDX_W         = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // One frame of FP32 logits at the default class count, class k in element k.
  typedef logic [NUM_CLASS_DEF-1:0][FP_W-1:0] logit_vec_t;

endpackage

// File: rtl/softmax_ctrl_if.sv
// Handshake bundle between the softmax controller, the upstream logit
// source, the external softmax datapath and the downstream consumer.
interface softmax_ctrl_if
  import softmax_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF
) ();

  // upstream logit stream
  logic                      in_valid;
  logic                      in_ready;
  logic [FP_W-1:0]           in_data;
  logic                      in_last;
  // softmax datapath
  logic                      sm_valid_in;
  logic [FP_W*NUM_CLASS-1:0] sm_logits;
  logic                      sm_valid_out;
  logic [FP_W*NUM_CLASS-1:0] sm_probs;
  // downstream probability stream
  logic                      out_valid;
  logic                      out_ready;
  logic [FP_W-1:0]           out_data;
  logic [IDX_W-1:0]          out_idx;
  logic                      out_last;

  // controller side
  modport slave (
    input  in_valid, in_data, in_last, sm_valid_out, sm_probs, out_ready,
    output in_ready, sm_valid_in, sm_logits, out_valid, out_data, out_idx, out_last
  );

  // environment side (source, datapath, sink)
  modport master (
    output in_valid, in_data, in_last, sm_valid_out, sm_probs, out_ready,
    input  in_ready, sm_valid_in, sm_logits, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/softmax_argmax.sv
// Combinational argmax over packed FP32 probabilities. Only the magnitude
// bits [30:0] are compared; ties resolve to the lowest class index.
// Instantiated by softmax_ctrl only when SOFTMAX_ARGMAX_EN is defined.
module softmax_argmax
  import softmax_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF
) (
  input  logic [FP_W*NUM_CLASS-1:0] probs_i,
  output logic [IDX_W-1:0]          best_idx_o
);

  // pad the leaf count to a power of two so the tree is balanced
  localparam int LEAVES = (NUM_CLASS > 1) ? (1 << $clog2(NUM_CLASS)) : 1;

  logic [FP_W-2:0]  leaf_val [LEAVES];
  logic             leaf_vld [LEAVES];
  logic [NUM_CLASS-1:0] sign_bits;
  logic             unused_sign_bits;

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < NUM_CLASS) begin : g_real
        assign leaf_val[gi]  = probs_i[FP_W*gi +: FP_W-1];
        assign leaf_vld[gi]  = 1'b1;
        assign sign_bits[gi] = probs_i[FP_W*gi + FP_W-1];
      end else begin : g_pad
        assign leaf_val[gi] = '0;
        assign leaf_vld[gi] = 1'b0;
      end
    end
  endgenerate

  // probabilities are never negative, so the sign bits carry no information
  assign unused_sign_bits = ^sign_bits;

  logic [FP_W-2:0]  node_val [LEAVES];
  logic [IDX_W-1:0] node_idx [LEAVES];
  logic             node_vld [LEAVES];

  // pairwise reduction: the left node always holds the lower indices, so the
  // right one wins only when strictly larger
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      node_val[i] = leaf_val[i];
      node_vld[i] = leaf_vld[i];
      node_idx[i] = IDX_W'(i);
    end
    for (int s = 1; s < LEAVES; s = s * 2) begin
      for (int i = 0; i + s < LEAVES; i = i + 2 * s) begin
        if (node_vld[i+s] && (!node_vld[i] || (node_val[i+s] > node_val[i]))) begin
          node_val[i] = node_val[i+s];
          node_idx[i] = node_idx[i+s];
          node_vld[i] = 1'b1;
        end
      end
    end
    best_idx_o = node_idx[0];
  end

endmodule

// File: rtl/softmax_ctrl.sv
// Frame controller around an external softmax datapath: collects NUM_CLASS
// logits, issues them, waits (bounded) for the probabilities and streams
// them out one class per transfer.
// Build option: SOFTMAX_ARGMAX_EN adds a registered argmax on best_idx;
// without it best_idx is tied to zero.
module softmax_ctrl
  import softmax_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               rst,
  softmax_ctrl_if.slave      bus,
  output logic [IDX_W-1:0]   best_idx,
  output logic               busy,
  output logic               err_frame,
  output logic               err_timeout
);

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]               rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [NUM_CLASS-1:0][FP_W-1:0] logits_q;
  logic [NUM_CLASS-1:0][FP_W-1:0] result_q;

  logic logit_we, capture;
  logic in_ready_c, sm_valid_in_c, out_valid_c, err_frame_c, err_timeout_c;

  // next-state and strobes; everything is forced low while rst is high so
  // an aborted frame never produces a stray pulse
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    cnt_d         = cnt_q;
    logit_we      = 1'b0;
    capture       = 1'b0;
    in_ready_c    = 1'b0;
    sm_valid_in_c = 1'b0;
    out_valid_c   = 1'b0;
    err_frame_c   = 1'b0;
    err_timeout_c = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            logit_we = 1'b1;
            if (wr_idx_q == LAST_IDX) begin
              // a full frame is issued even if in_last was missing
              err_frame_c = ~bus.in_last;
              wr_idx_d    = '0;
              state_d     = ISSUE;
            end else if (bus.in_last) begin
              err_frame_c = 1'b1;
              wr_idx_d    = '0;
            end else begin
              wr_idx_d = wr_idx_q + 1'b1;
            end
          end
        end
        ISSUE: begin
          sm_valid_in_c = 1'b1;
          cnt_d         = '0;
          state_d       = WAIT;
        end
        WAIT: begin
          // a result arriving on the last allowed cycle still counts
          if (bus.sm_valid_out) begin
            capture = 1'b1;
            state_d = DRAIN;
          end else if (cnt_q == CNT_MAX) begin
            err_timeout_c = 1'b1;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          out_valid_c = 1'b1;
          if (bus.out_ready) begin
            if (rd_idx_q == LAST_IDX) begin
              rd_idx_d = '0;
              state_d  = IDLE;
            end else begin
              rd_idx_d = rd_idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, indices and the logit/result storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
      logits_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
      if (logit_we) logits_q[wr_idx_q] <= bus.in_data;
      if (capture)  result_q <= bus.sm_probs;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.sm_valid_in = sm_valid_in_c;
  assign bus.sm_logits   = logits_q;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = out_valid_c ? result_q[rd_idx_q] : '0;
  assign bus.out_idx     = rd_idx_q;
  assign bus.out_last    = out_valid_c && (rd_idx_q == LAST_IDX);
  assign busy            = !rst && (state_q != IDLE);
  assign err_frame       = err_frame_c;
  assign err_timeout     = err_timeout_c;

`ifdef SOFTMAX_ARGMAX_EN
  logic [IDX_W-1:0] argmax_idx;
  logic [IDX_W-1:0] best_idx_q;

  softmax_argmax #(.NUM_CLASS(NUM_CLASS)) u_argmax (
    .probs_i    (bus.sm_probs),
    .best_idx_o (argmax_idx)
  );

  // argmax is taken together with the result so it holds through DRAIN
  always_ff @(posedge clk) begin
    if (rst)          best_idx_q <= '0;
    else if (capture) best_idx_q <= argmax_idx;
  end

  assign best_idx = best_idx_q;
`else
  assign best_idx = '0;
`endif

endmodule
